// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default timing constants.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_engine_if.sv
// Read side of the show-ahead TX FIFO as seen by the transmit engine.
interface uart_tx_engine_if;
  import uart_pkg::*;

  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_read_data;
  logic                      fifo_read_en;

  // master: the engine draining the FIFO; slave: the FIFO itself
  modport master (
    input  fifo_empty,
    input  fifo_read_data,
    output fifo_read_en
  );

  modport slave (
    output fifo_empty,
    output fifo_read_data,
    input  fifo_read_en
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: drains the TX FIFO and serialises each byte as an 8N1 frame.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tx_enable,
  uart_tx_engine_if.master         fifo_bus,
  output logic                     tx,
  output logic                     busy,
  output logic                     tx_done
);

  tx_state_e                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic                      tx_q, tx_d;
  logic                      tick;
  logic                      can_pop;
  logic                      pop;
  logic                      done;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (pop),
    .en     (state_q != StIdle),
    .tick   (tick)
  );

  // Gated by reset_n so the combinational strobes drop with the async reset.
  assign can_pop = reset_n && tx_enable && !fifo_bus.fifo_empty;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    pop       = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (can_pop) begin
          pop     = 1'b1;
          shift_d = fifo_bus.fifo_read_data;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          done = 1'b1;
          // Chain straight into the next frame so back-to-back bytes have no idle gap.
          if (can_pop) begin
            pop     = 1'b1;
            shift_d = fifo_bus.fifo_read_data;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is registered from the upcoming state so tx changes the cycle after a pop.
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
    end
  end

  assign fifo_bus.fifo_read_en = pop;
  assign tx                    = tx_q;
  assign busy                  = (state_q != StIdle) || pop;
  assign tx_done               = done;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine with CLKS_PER_BIT=4 and a small show-ahead FIFO model.
module tb_uart_tx_engine;

  localparam int unsigned Cpb = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic tx_enable;
  logic tx;
  logic busy;
  logic tx_done;

  logic [7:0] mem [16];
  logic [3:0] rd_ptr = '0;
  logic [3:0] wr_ptr = '0;
  int         fifo_cnt = 0;

  int total = 0;
  int bad   = 0;

  uart_tx_engine_if fif ();

  assign fif.fifo_empty     = (fifo_cnt == 0);
  assign fif.fifo_read_data = mem[rd_ptr];

  uart_tx_engine #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_enable(tx_enable),
    .fifo_bus (fif),
    .tx       (tx),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr      = wr_ptr + 4'd1;
    fifo_cnt    = fifo_cnt + 1;
  endtask

  // Advance one clock; the FIFO pops if read_en was high before the edge.
  task automatic step();
    logic seen;
    @(negedge clk);
    seen = fif.fifo_read_en;
    @(posedge clk);
    #1;
    if (seen) begin
      rd_ptr   = rd_ptr + 4'd1;
      fifo_cnt = fifo_cnt - 1;
    end
    #1;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int idx;
    idx = k / Cpb;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Entered on the pop cycle; walks the 40 frame cycles that follow.
  task automatic run_frame(input logic [7:0] b, input logic chain, input int drop_at,
                           input int stop_at);
    check_eq("pop", fif.fifo_read_en, 1);
    check_eq("busy_pop", busy, 1);
    for (int k = 0; k < 10 * Cpb; k++) begin
      step();
      check_eq("tx", tx, frame_bit(b, k));
      check_eq("busy", busy, 1);
      check_eq("done", tx_done, (k == 10 * Cpb - 1));
      if (k == 10 * Cpb - 1) check_eq("chain_pop", fif.fifo_read_en, chain);
      else                   check_eq("rden", fif.fifo_read_en, 0);
      if (k == drop_at) tx_enable = 1'b0;
      if (k == stop_at) return;
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_tx"}, tx, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_rden"}, fif.fifo_read_en, 0);
    check_eq({tag, "_done"}, tx_done, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    tx_enable = 1'b1;
    push(8'hA5);

    // Reset held with data waiting
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("rst");
    end
    reset_n = 1'b1;
    #1;

    // Single byte 0xA5, popped on the first IDLE cycle
    run_frame(8'hA5, 1'b0, -1, -1);
    step();
    check_idle("a5_end");
    check_eq("a5_fifo", fifo_cnt, 0);

    // Back-to-back 0x00 then 0xFF
    push(8'h00);
    push(8'hFF);
    #1;
    run_frame(8'h00, 1'b1, -1, -1);
    run_frame(8'hFF, 1'b0, -1, -1);
    step();
    check_idle("b2b_end");

    // tx_enable drops at cycle 10 of the 0x3C frame with 0x55 queued
    tx_enable = 1'b0;
    push(8'h3C);
    push(8'h55);
    #1;
    check_eq("gated", fif.fifo_read_en, 0);
    tx_enable = 1'b1;
    #1;
    run_frame(8'h3C, 1'b0, 10, -1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle("dis");
    end
    check_eq("dis_fifo", fifo_cnt, 1);
    tx_enable = 1'b1;
    #1;
    run_frame(8'h55, 1'b0, -1, -1);
    step();
    check_idle("55_end");

    // Async reset mid-DATA of 0x96 with 0x81 queued
    push(8'h96);
    push(8'h81);
    #1;
    run_frame(8'h96, 1'b0, -1, 18);
    check_eq("pre_rst_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("arst");
    step();
    check_idle("arst_hold");
    reset_n = 1'b1;
    #1;
    run_frame(8'h81, 1'b0, -1, -1);
    step();
    check_idle("81_end");

    // Empty FIFO with tx_enable high
    for (int i = 0; i < 100; i++) begin
      step();
      check_idle("empty");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
